// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, credit-limited imem requests, in-order FIFO to decoder
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   tag_q       [DEPTH];
    logic          fault;

    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    // Every redirect re-evaluates the fault: misaligned sets it, aligned clears it.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Credit covers both outstanding requests and buffered words, so a response always has a slot.
    assign occupancy      = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_valid = !rst && !fault && !redirect_valid && (occupancy < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (count_q != '0) && !fault;
    assign instr          = fifo_data_q[fifo_rd_q];
    assign instr_pc       = fifo_pc_q[fifo_rd_q];
    assign fetch_fault    = fault;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign push     = imem_resp_valid && (drop_q == '0) && !redirect_valid;
    assign pop      = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
        drop_d     = drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        fifo_rd_d  = pop  ? ptr_inc(fifo_rd_q) : fifo_rd_q;
        fifo_wr_d  = push ? ptr_inc(fifo_wr_q) : fifo_wr_q;
        tag_rd_d   = imem_resp_valid ? ptr_inc(tag_rd_q) : tag_rd_q;
        tag_wr_d   = req_fire ? ptr_inc(tag_wr_q) : tag_wr_q;

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        // Anything still outstanding after this edge belongs to the old path.
        if (redirect_valid) begin
            pc_d      = redirect_pc & 32'hFFFF_FFFC;
            drop_d    = inflight_q - CW'(imem_resp_valid);
            count_d   = '0;
            fifo_wr_d = fifo_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            if (push) begin
                fifo_pc_q[fifo_wr_q]   <= tag_q[tag_rd_q];
                fifo_data_q[fifo_wr_q] <= imem_resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference state: outstanding requests (pc, stale, due cycle) and buffered instructions.
    logic [31:0] out_pc[$];
    bit          out_stale[$];
    int          out_due[$];
    logic [31:0] fq_pc[$];
    logic [31:0] fq_w[$];
    logic [31:0] m_pc;
    bit          m_fault;
    int          cyc;
    int          last_due;
    int          lat_min, lat_max, req_pct;
    bit          last_iv;

    task automatic tick(input bit ird, input bit rv, input logic [31:0] rpc);
        bit          resp, exp_rv, exp_iv, acc, pop, st;
        logic [31:0] p;
        int          due;
        resp = (out_pc.size() > 0) && (out_due[0] <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(out_pc[0]) : $urandom;
        imem_req_ready  = ($urandom_range(99) < req_pct);
        instr_ready     = ird;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        exp_rv = !m_fault && !rv && ((out_pc.size() + fq_pc.size()) < DEPTH);
        exp_iv = (fq_pc.size() != 0) && !m_fault;
        #1;
        last_iv = instr_valid;
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("instr_pc", instr_pc, fq_pc[0]);
            check("instr", instr, fq_w[0]);
        end
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        @(posedge clk);
        acc = exp_rv && imem_req_ready;
        pop = exp_iv && ird && !rv;
        st  = 1'b0;
        p   = '0;
        if (resp) begin
            p  = out_pc.pop_front();
            st = out_stale.pop_front();
            void'(out_due.pop_front());
        end
        if (pop) begin
            void'(fq_pc.pop_front());
            void'(fq_w.pop_front());
        end
        if (resp && !st && !rv) begin
            fq_pc.push_back(p);
            fq_w.push_back(mem_word(p));
        end
        if (rv) begin
            fq_pc.delete();
            fq_w.delete();
            foreach (out_stale[i]) out_stale[i] = 1'b1;
            m_pc = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_fault = (rpc[1:0] != 2'b00);
`endif
        end
        if (acc) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            out_pc.push_back(m_pc);
            out_stale.push_back(1'b0);
            out_due.push_back(due);
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int rdy_pct);
        for (int i = 0; i < n; i++) tick($urandom_range(99) < rdy_pct, 1'b0, '0);
    endtask

    initial begin
        int          first_iv;
        bit          hit;
        logic [31:0] rpc;
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        m_pc = RESET_PC; m_fault = 1'b0; cyc = 0; last_due = -1;
        lat_min = 1; lat_max = 1; req_pct = 100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        rst = 1'b0;

        first_iv = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, '0);
            if (first_iv < 0 && last_iv) first_iv = i;
        end
        check("first_instr_cycle", 32'(first_iv), 32'd2);

        run(10, 0);
        run(10, 100);

        lat_min = 3; lat_max = 3;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (out_pc.size() == 2) begin
                tick(1'b1, 1'b1, 32'h0000_0200);
                hit = 1'b1;
            end else begin
                tick(1'b1, 1'b0, '0);
            end
        end
        check("redirect_two_outstanding", 32'(hit), 32'd1);
        run(15, 100);

        lat_min = 1; lat_max = 1;
        run(5, 100);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (out_pc.size() > 0 && out_due[0] <= cyc && fq_pc.size() != 0) begin
                tick(1'b1, 1'b1, 32'h0000_0400);
                hit = 1'b1;
            end else begin
                tick(1'b1, 1'b0, '0);
            end
        end
        check("redirect_with_resp_and_pop", 32'(hit), 32'd1);
        run(8, 100);

        tick(1'b1, 1'b1, 32'hFFFF_FFFC);
        run(10, 100);

        tick(1'b1, 1'b1, 32'h0000_0202);
        run(8, 100);
        tick(1'b1, 1'b1, 32'h0000_0300);
        run(10, 100);

        lat_min = 1; lat_max = 4; req_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 5) begin
                rpc = $urandom;
                if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
                if ($urandom_range(7) == 0) rpc[31:4] = '1;
                tick($urandom_range(99) < 70, 1'b1, rpc);
            end else begin
                tick($urandom_range(99) < 70, 1'b0, '0);
            end
        end
        tick(1'b1, 1'b1, 32'h0000_0800);
        run(20, 100);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
